dff_shift_register: RTL and testbench

//   Parametrised successor of the single NAND-built D flip-flop cell. Provides a

---
 rtl/dff_shift_register.sv | 81 ++++++++
 tb/tb_dff_shift_register.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dff_shift_register.sv
// WIDTH-bit edge-triggered register with complementary outputs, hold, parallel load,
// shift left/right, synchronous clear/preset and a one-cycle change flag.
module dff_shift_register #(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sclr,
    input  logic             spre,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout_r,
    output logic             sout_l,
    output logic             changed
);

    typedef enum logic [1:0] {
        ModeHold  = 2'b00,
        ModeShr   = 2'b01,
        ModeShl   = 2'b10,
        ModeLoad  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] shr_val, shl_val;

    // Shift candidates; a 1-bit register simply takes the serial input.
    if (WIDTH == 1) begin : g_w1
        assign shr_val = ser_in_r;
        assign shl_val = ser_in_l;
    end else begin : g_wn
        assign shr_val = {ser_in_r, q_q[WIDTH-1:1]};
        assign shl_val = {q_q[WIDTH-2:0], ser_in_l};
    end

    // Next-state selection: clear beats preset, both ignore en; then en-gated mode.
    always_comb begin
        q_d = q_q;
        if (sclr) begin
            q_d = '0;
        end else if (spre) begin
            q_d = '1;
        end else if (en) begin
            unique case (mode_e'(mode))
                ModeHold: q_d = q_q;
                ModeShr:  q_d = shr_val;
                ModeShl:  q_d = shl_val;
                ModeLoad: q_d = d;
                default:  q_d = q_q;
            endcase
        end
        // Flag only real value changes, so equal loads or clears on zero stay quiet.
        changed_d = (q_d != q_q);
    end

    // State register with asynchronous reset that also aborts any pending operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
        end
    end

    // Combinational taps of the stored value.
    assign q       = q_q;
    assign q_n     = ~q_q;
    assign sout_r  = q_q[0];
    assign sout_l  = q_q[WIDTH-1];
    assign changed = changed_q;

endmodule

// File: tb/tb_dff_shift_register.sv
// Directed bench for dff_shift_register: an 8-bit instance (RESET_VAL=A5) and a 1-bit one.
module tb_dff_shift_register;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, sclr, spre, ser_in_r, ser_in_l;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q, q_n;
    logic       sout_r, sout_l, changed;
    logic       d1, q1, q1_n, sout1_r, sout1_l, changed1;

    int checks = 0;
    int errors = 0;

    dff_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sclr     (sclr),
        .spre     (spre),
        .mode     (mode),
        .d        (d),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .q        (q),
        .q_n      (q_n),
        .sout_r   (sout_r),
        .sout_l   (sout_l),
        .changed  (changed)
    );

    dff_shift_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sclr     (sclr),
        .spre     (spre),
        .mode     (mode),
        .d        (d1),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .q        (q1),
        .q_n      (q1_n),
        .sout_r   (sout1_r),
        .sout_l   (sout1_l),
        .changed  (changed1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] shr_exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    logic       sr_exp  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b1; en = 1'b0; sclr = 1'b0; spre = 1'b0; mode = 2'b00;
        d = 8'h00; d1 = 1'b0; ser_in_r = 1'b0; ser_in_l = 1'b0;

        // 1. Asynchronous reset mid-cycle, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'h A5);
        check("rst_qn", 32'(q_n), 32'h5A);
        check("rst_changed", 32'(changed), 32'h0);
        check("rst_q1", 32'(q1), 32'h0);
        check("rst_q1n", 32'(q1_n), 32'h1);
        step();
        check("rst_hold_q", 32'(q), 32'hA5);
        rst_n = 1'b1;

        // 2. Load then hold
        en = 1'b1; mode = 2'b11; d = 8'h3C;
        step();
        check("load_q", 32'(q), 32'h3C);
        check("load_qn", 32'(q_n), 32'hC3);
        check("load_changed", 32'(changed), 32'h1);
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_q", 32'(q), 32'h3C);
            check("hold_changed", 32'(changed), 32'h0);
        end

        // 3. Shift right from 81
        mode = 2'b11; d = 8'h81;
        step();
        check("shr_sout_l", 32'(sout_l), 32'h1);
        mode = 2'b01; ser_in_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("shr_sout_r", 32'(sout_r), 32'(sr_exp[i]));
            step();
            check("shr_q", 32'(q), 32'(shr_exp[i]));
        end

        // 4. Shift left with en gating
        mode = 2'b11; d = 8'h01;
        step();
        mode = 2'b10; ser_in_l = 1'b1;
        en = 1'b1; step();
        check("shl_q0", 32'(q), 32'h03);
        check("shl_ch0", 32'(changed), 32'h1);
        en = 1'b0; step();
        check("shl_q1", 32'(q), 32'h03);
        check("shl_ch1", 32'(changed), 32'h0);
        en = 1'b1; step();
        check("shl_q2", 32'(q), 32'h07);
        check("shl_ch2", 32'(changed), 32'h1);

        // 5. Priority: clear beats preset and load; preset ignores en
        sclr = 1'b1; spre = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hFF;
        step();
        check("prio_clr_q", 32'(q), 32'h00);
        sclr = 1'b0; spre = 1'b1; en = 1'b0;
        step();
        check("prio_pre_q", 32'(q), 32'hFF);
        check("prio_pre_qn", 32'(q_n), 32'h00);
        check("prio_pre_ch", 32'(changed), 32'h1);
        spre = 1'b0;

        // 6. Redundant load and clear on zero leave changed low
        en = 1'b1; mode = 2'b11; d = 8'h3C;
        step();
        check("redun_ch0", 32'(changed), 32'h1);
        step();
        check("redun_q", 32'(q), 32'h3C);
        check("redun_ch1", 32'(changed), 32'h0);
        sclr = 1'b1;
        step();
        check("clr_ch0", 32'(changed), 32'h1);
        step();
        check("clr_zero_ch", 32'(changed), 32'h0);
        sclr = 1'b0;

        // Reset aborts a pending load
        mode = 2'b11; d = 8'h5F;
        rst_n = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'hA5);
        step();
        check("abort_hold_q", 32'(q), 32'hA5);
        check("abort_ch", 32'(changed), 32'h0);
        rst_n = 1'b1;

        // WIDTH=1 shifts
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check("w1_clr", 32'(q1), 32'h0);
        mode = 2'b01; ser_in_r = 1'b1; ser_in_l = 1'b0;
        step();
        check("w1_shr_q", 32'(q1), 32'h1);
        check("w1_shr_qn", 32'(q1_n), 32'h0);
        check("w1_shr_ch", 32'(changed1), 32'h1);
        check("w1_taps", 32'({sout1_r, sout1_l}), 32'h3);
        mode = 2'b10; ser_in_l = 1'b0;
        step();
        check("w1_shl_q0", 32'(q1), 32'h0);
        ser_in_l = 1'b1;
        step();
        check("w1_shl_q1", 32'(q1), 32'h1);
        step();
        check("w1_shl_same_ch", 32'(changed1), 32'h0);
        mode = 2'b01; ser_in_r = 1'b0;
        step();
        check("w1_shr_q0", 32'(q1), 32'h0);
        check("w1_shr_ch0", 32'(changed1), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
